// File: rtl/cla_seq_adder.sv
// Byte-serial WIDTH-bit adder sharing one 8-bit cla_block; optional subtract via CLA_SEQ_SUB_EN.
// Latency: result_valid rises N=WIDTH/8 edges after accept; in_ready only in IDLE.
// Backpressure: result and flags are held in DONE until result_ready; start is never queued.

module cla_block (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] sum,
  output logic       g,
  output logic       p
);
  logic [7:0] gi, pi, gpre, ppre;
  logic [8:0] c;

  // Prefix generate/propagate so each carry comes straight from ci, not the previous carry.
  always_comb begin
    gi      = a & b;
    pi      = a ^ b;
    gpre    = '0;
    ppre    = '0;
    c       = '0;
    c[0]    = ci;
    gpre[0] = gi[0];
    ppre[0] = pi[0];
    for (int i = 1; i < 8; i++) begin
      gpre[i] = gi[i] | (pi[i] & gpre[i-1]);
      ppre[i] = pi[i] & ppre[i-1];
    end
    for (int i = 0; i < 8; i++) begin
      c[i+1] = gpre[i] | (ppre[i] & ci);
    end
    sum = pi ^ c[7:0];
    g   = gpre[7];
    p   = ppre[7];
  end
endmodule

module cla_seq_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             result_valid,
  input  logic             result_ready
);
  localparam int N  = WIDTH / 8;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [7:0]       a_slice, b_slice, slice_sum;
  logic             slice_g, slice_p, slice_co;

`ifdef CLA_SEQ_SUB_EN
  assign b_eff   = sub ? ~op_b : op_b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign b_eff   = op_b;
  assign cin_eff = cin;
`endif

  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int k = 0; k < N; k++) begin
      if (cnt == CW'(k)) begin
        a_slice = a_reg[8*k +: 8];
        b_slice = b_reg[8*k +: 8];
      end
    end
  end

  cla_block u_slice (
    .a   (a_slice),
    .b   (b_slice),
    .ci  (carry_reg),
    .sum (slice_sum),
    .g   (slice_g),
    .p   (slice_p)
  );

  assign slice_co = slice_g | (slice_p & carry_reg);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      result       <= '0;
      cout         <= 1'b0;
      overflow     <= 1'b0;
      zero         <= 1'b0;
      result_valid <= 1'b0;
      cnt          <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      carry_reg    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg     <= op_a;
            b_reg     <= b_eff;
            carry_reg <= cin_eff;
            cnt       <= '0;
            result    <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            in_ready  <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < N; k++) begin
            if (cnt == CW'(k)) result[8*k +: 8] <= slice_sum;
          end
          carry_reg <= slice_co;
          if (cnt == CW'(N-1)) begin
            cout         <= slice_co;
            overflow     <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) & (slice_sum[7] != a_reg[WIDTH-1]);
            // Lower bytes are already in result; the top byte is only on the slice output.
            zero         <= (slice_sum == 8'h00) & (result[WIDTH-9:0] == '0);
            result_valid <= 1'b1;
            state        <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            in_ready     <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_seq_adder.sv
// Randomized bench for cla_seq_adder against an arithmetic reference model, plus directed literal cases.
module tb_cla_seq_adder;
  localparam int W = 32;
  localparam int N = W / 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] result;
  logic         cout, overflow, zero, result_valid;
  logic         result_ready = 1'b0;
  logic         sub_eff;

  int nvec = 0;
  int errs = 0;
  int ncmp = 0;

  cla_seq_adder #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .in_ready     (in_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .cin          (cin),
`ifdef CLA_SEQ_SUB_EN
    .sub          (sub),
`endif
    .result       (result),
    .cout         (cout),
    .overflow     (overflow),
    .zero         (zero),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

`ifdef CLA_SEQ_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 computing, 2 holding a result.
  int         m_mode = 0;
  int         m_k = 0;
  logic [W:0] m_sum;
  logic [W-1:0] m_a, m_b, m_res = '0;
  logic       m_cout = 0, m_ovf = 0, m_zero = 0;
  bit         chk_en = 0;

  function automatic logic [W-1:0] lowmask(input int k);
    logic [63:0] m;
    m = (64'd1 << (8 * k)) - 64'd1;
    return m[W-1:0];
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_mode = 0; m_k = 0; m_res = '0; m_cout = 0; m_ovf = 0; m_zero = 0;
      chk_en = 1;
    end else begin
      case (m_mode)
        0: if (start) begin
          m_a   = op_a;
          m_b   = sub_eff ? ~op_b : op_b;
          m_sum = {1'b0, m_a} + {1'b0, m_b} + ((sub_eff | cin) ? 33'd1 : 33'd0);
          m_res = '0; m_cout = 0; m_ovf = 0; m_zero = 0;
          m_k   = 0;
          m_mode = 1;
          nvec++;
        end
        1: begin
          m_k++;
          m_res = m_sum[W-1:0] & lowmask(m_k);
          if (m_k == N) begin
            m_cout = m_sum[W];
            m_ovf  = (m_a[W-1] == m_b[W-1]) && (m_sum[W-1] != m_a[W-1]);
            m_zero = (m_sum[W-1:0] == '0);
            m_mode = 2;
          end
        end
        default: if (result_ready) m_mode = 0;
      endcase
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("in_ready", 64'(in_ready), 64'(m_mode == 0));
      chk("result_valid", 64'(result_valid), 64'(m_mode == 2));
      chk("result", 64'(result), 64'(m_res));
      chk("cout", 64'(cout), 64'(m_cout));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("zero", 64'(zero), 64'(m_zero));
    end
  end

  task automatic wait_valid(input string nm, output int edges);
    edges = 0;
    do begin
      @(posedge clock);
      edges++;
      #1;
    end while (!result_valid && edges < 20);
    if (!result_valid) chk({nm, "_timeout"}, 64'(result_valid), 64'd1);
  endtask

  task automatic drain();
    @(negedge clock); result_ready = 1'b1;
    @(posedge clock);
    @(negedge clock); result_ready = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s,
                        input logic [W-1:0] er, input logic ec, input logic eo, input logic ez,
                        input string nm, input bit do_drain);
    int edges;
    @(negedge clock);
    chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    op_a = a; op_b = b; cin = c; sub = s; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0; op_a = $urandom; op_b = $urandom; cin = $urandom; sub = $urandom;
    wait_valid(nm, edges);
    chk({nm, "_latency"}, 64'(edges), 64'(N));
    chk({nm, "_res"}, 64'(result), 64'(er));
    chk({nm, "_cout"}, 64'(cout), 64'(ec));
    chk({nm, "_ovf"}, 64'(overflow), 64'(eo));
    chk({nm, "_zero"}, 64'(zero), 64'(ez));
    if (do_drain) drain();
  endtask

  initial begin
    int edges;
    // Reset held for two cycles
    repeat (2) @(posedge clock);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_valid", 64'(result_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    @(negedge clock); reset = 1'b0;

    run_op(32'h000000FF, 32'h1, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0, "t2", 1);
    run_op(32'hFFFFFFFF, 32'h1, 1'b1, 1'b0, 32'h00000001, 1'b1, 1'b0, 1'b0, "t3a", 1);
    run_op(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, "t3b", 1);
    run_op(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, "t4", 1);

    // Backpressure in DONE with start held high
    run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0, "t5", 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); start = 1'b1; op_a = 32'hA; op_b = 32'hB; cin = 1'b0; sub = 1'b0;
      @(posedge clock); #1;
      chk("t5_hold_in_ready", 64'(in_ready), 64'd0);
      chk("t5_hold_valid", 64'(result_valid), 64'd1);
      chk("t5_hold_res", 64'(result), 64'h23456789);
    end
    @(negedge clock); result_ready = 1'b1;
    @(posedge clock); #1;
    chk("t5_idle_in_ready", 64'(in_ready), 64'd1);
    chk("t5_idle_valid", 64'(result_valid), 64'd0);
    @(negedge clock); result_ready = 1'b0;
    @(posedge clock); #1;
    chk("t5_accept", 64'(in_ready), 64'd0);
    @(negedge clock); start = 1'b0;
    wait_valid("t5b", edges);
    chk("t5b_res", 64'(result), 64'h15);
    drain();

    // Reset pulsed mid-run after two slices
    @(negedge clock); op_a = 32'hDEADBEEF; op_b = 32'h01020304; start = 1'b1;
    @(posedge clock);
    @(negedge clock); start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("t6_partial", 64'(result), 64'(32'hDEADBEEF + 32'h01020304) & 64'hFFFF);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    chk("t6_in_ready", 64'(in_ready), 64'd1);
    chk("t6_valid", 64'(result_valid), 64'd0);
    chk("t6_res", 64'(result), 64'd0);
    chk("t6_flags", 64'({cout, overflow, zero}), 64'd0);
    @(negedge clock); reset = 1'b0;
`ifdef CLA_SEQ_SUB_EN
    run_op(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, "t6_sub", 1);
`else
    run_op(32'd5, 32'd7, 1'b0, 1'b1, 32'd12, 1'b0, 1'b0, 1'b0, "t6_add", 1);
`endif

    // Random traffic: the compare process checks every cycle against the model.
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      start        = ($urandom_range(0, 2) == 0);
      result_ready = $urandom_range(0, 1);
      cin          = $urandom_range(0, 1);
      sub          = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0:       op_a = 32'hFFFFFFFF;
        1:       op_a = 32'h7FFFFFFF;
        2:       op_a = 32'h80000000;
        default: op_a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       op_b = 32'h0;
        1:       op_b = 32'h1;
        2:       op_b = ~op_a;
        default: op_b = $urandom;
      endcase
    end
    @(negedge clock); start = 1'b0; result_ready = 1'b1;
    repeat (N + 3) @(posedge clock);
    @(negedge clock);
    chk("final_idle", 64'(in_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end
endmodule
